lieat_exu_mul_iter: RTL and testbench



---
 rtl/lieat_mul_pkg.sv | 29 ++
 rtl/lieat_exu_booth_pp.sv | 29 ++
 rtl/lieat_exu_mul_iter.sv | 165 ++++++++++++++++
 tb/tb_lieat_exu_mul_iter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lieat_mul_pkg.sv
// Shared definitions for the iterative radix-4 Booth multiplier:
// RISC-V M op encodings, one-hot FSM states and digit/cycle count helpers.
package lieat_mul_pkg;

  localparam logic [1:0] MUL_OP_MUL    = 2'b00;
  localparam logic [1:0] MUL_OP_MULH   = 2'b01;
  localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
  localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

  localparam int MUL_ST_W = 4;

  typedef enum logic [MUL_ST_W-1:0] {
    MUL_ST_IDLE = 4'b0001,
    MUL_ST_CALC = 4'b0010,
    MUL_ST_SIGN = 4'b0100,
    MUL_ST_DONE = 4'b1000
  } mul_state_e;

  // Radix-4 digits needed for an XLEN-bit unsigned magnitude (one extra digit
  // absorbs the top magnitude bit so the last digit is never negative).
  function automatic int mul_nd(input int xlen);
    return xlen / 2 + 1;
  endfunction

  function automatic int mul_nc(input int xlen, input int dpc);
    return (mul_nd(xlen) + dpc - 1) / dpc;
  endfunction

endpackage

// File: rtl/lieat_exu_booth_pp.sv
// One radix-4 Booth digit applied to the multiplicand magnitude, giving a
// 2*XLEN-bit two's-complement partial product in {0, +-M, +-2M}.
module lieat_exu_booth_pp
  #(parameter int XLEN = 32)
  (
    input  logic [2:0]        digit,
    input  logic [XLEN-1:0]   mcand,
    output logic [2*XLEN-1:0] pp
  );

  logic [2*XLEN-1:0] m1;
  logic [2*XLEN-1:0] m2;

  assign m1 = {{XLEN{1'b0}}, mcand};
  assign m2 = {{(XLEN-1){1'b0}}, mcand, 1'b0};

  // Negating the zero-extended magnitude yields the sign-extended negative.
  always_comb begin
    pp = '0;
    case (digit)
      3'b001, 3'b010: pp = m1;
      3'b011:         pp = m2;
      3'b100:         pp = '0 - m2;
      3'b101, 3'b110: pp = '0 - m1;
      default:        pp = '0;
    endcase
  end

endmodule

// File: rtl/lieat_exu_mul_iter.sv
// Iterative radix-4 Booth multiplier: magnitudes are multiplied DPC digits per
// cycle through a carry-save tree, then the sign is applied in one extra cycle.
module lieat_exu_mul_iter
  import lieat_mul_pkg::*;
  #(
    parameter int XLEN = 32,
    parameter int DPC  = 4
  )
  (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            mul_i_valid,
    output logic            mul_i_ready,
    input  logic [1:0]      mul_i_op,
    input  logic [XLEN-1:0] mul_i_multiplicand,
    input  logic [XLEN-1:0] mul_i_multiplier,
    output logic            mul_o_valid,
    input  logic            mul_o_ready,
    output logic [XLEN-1:0] mul_o_res,
    output logic [XLEN-1:0] mul_o_resh,
    output logic [XLEN-1:0] mul_o_resl
  );

  // Handshake: a request transfers on a rising edge with mul_i_valid &
  // mul_i_ready; a result transfers on a rising edge with mul_o_valid &
  // mul_o_ready. Flush overrides both transfers in the same cycle.

  localparam int PW = 2 * XLEN;
  localparam int NC = mul_nc(XLEN, DPC);
  // Multiplier shift register padded so every digit slot of every cycle exists.
  localparam int BW = 2 * DPC * NC + 1;
  localparam int CW = (NC > 1) ? $clog2(NC) : 1;

  mul_state_e       state_q, state_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic [XLEN-1:0]  mcand_q, mcand_d;
  logic [BW-1:0]    mplr_q, mplr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [1:0]       op_q, op_d;
  logic             neg_q, neg_d;

  logic             signed1, signed2;
  logic             neg1, neg2;
  logic [XLEN-1:0]  abs1, abs2;
  logic             zero_in;

  logic [PW-1:0]    pp    [DPC];
  logic [PW-1:0]    pp_sh [DPC];
  logic [PW-1:0]    csa_s, csa_c, csa_ts, csa_tc;
  logic [PW-1:0]    calc_sum;

  // Operand decode on the request side.
  always_comb begin
    signed1 = (mul_i_op == MUL_OP_MULH) || (mul_i_op == MUL_OP_MULHSU);
    signed2 = (mul_i_op == MUL_OP_MULH);
    neg1    = signed1 & mul_i_multiplicand[XLEN-1];
    neg2    = signed2 & mul_i_multiplier[XLEN-1];
    abs1    = neg1 ? ('0 - mul_i_multiplicand) : mul_i_multiplicand;
    abs2    = neg2 ? ('0 - mul_i_multiplier)   : mul_i_multiplier;
    zero_in = (mul_i_multiplicand == '0) || (mul_i_multiplier == '0);
  end

  for (genvar j = 0; j < DPC; j++) begin : g_pp
    lieat_exu_booth_pp #(.XLEN(XLEN)) u_pp (
      .digit (mplr_q[2*j+2 -: 3]),
      .mcand (mcand_q),
      .pp    (pp[j])
    );
  end

  // Digit j of this cycle has absolute index count*DPC + j.
  always_comb begin
    for (int j = 0; j < DPC; j++) begin
      pp_sh[j] = pp[j] << (2 * DPC * int'(count_q) + 2 * j);
    end
  end

  // 3:2 compression of the running product and all partial products.
  always_comb begin
    csa_s  = prod_q;
    csa_c  = '0;
    csa_ts = '0;
    csa_tc = '0;
    for (int j = 0; j < DPC; j++) begin
      csa_ts = csa_s ^ csa_c ^ pp_sh[j];
      csa_tc = ((csa_s & csa_c) | (csa_s & pp_sh[j]) | (csa_c & pp_sh[j])) << 1;
      csa_s  = csa_ts;
      csa_c  = csa_tc;
    end
    calc_sum = csa_s + csa_c;
  end

  always_comb begin
    state_d = state_q;
    prod_d  = prod_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    count_d = count_q;
    op_d    = op_q;
    neg_d   = neg_q;
    if (flush) begin
      state_d = MUL_ST_IDLE;
    end else begin
      case (state_q)
        MUL_ST_IDLE: begin
          if (mul_i_valid) begin
            op_d    = mul_i_op;
            neg_d   = neg1 ^ neg2;
            mcand_d = abs1;
            mplr_d  = {{(BW-XLEN-1){1'b0}}, abs2, 1'b0};
            count_d = '0;
            prod_d  = '0;
            state_d = zero_in ? MUL_ST_DONE : MUL_ST_CALC;
          end
        end
        MUL_ST_CALC: begin
          prod_d  = calc_sum;
          mplr_d  = mplr_q >> (2 * DPC);
          count_d = count_q + CW'(1);
          if (count_q == CW'(NC - 1)) begin
            state_d = MUL_ST_SIGN;
          end
        end
        MUL_ST_SIGN: begin
          prod_d  = neg_q ? ('0 - prod_q) : prod_q;
          state_d = MUL_ST_DONE;
        end
        MUL_ST_DONE: begin
          if (mul_o_ready) begin
            state_d = MUL_ST_IDLE;
          end
        end
        default: state_d = MUL_ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MUL_ST_IDLE;
      prod_q  <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      count_q <= '0;
      op_q    <= MUL_OP_MUL;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prod_q  <= prod_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      count_q <= count_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
    end
  end

  assign mul_i_ready = (state_q == MUL_ST_IDLE);
  assign mul_o_valid = (state_q == MUL_ST_DONE);
  assign mul_o_resh  = prod_q[PW-1:XLEN];
  assign mul_o_resl  = prod_q[XLEN-1:0];
  assign mul_o_res   = (op_q == MUL_OP_MUL) ? prod_q[XLEN-1:0] : prod_q[PW-1:XLEN];

endmodule

// File: tb/tb_lieat_exu_mul_iter.sv
// Self-checking bench for lieat_exu_mul_iter: table vectors, hand-written
// stall/flush/reset sequences and random ops against a wide-multiply model.
module tb_lieat_exu_mul_iter;

  localparam int XLEN = 32;
  localparam int DPC  = 4;
  localparam int ND   = XLEN / 2 + 1;
  localparam int NC   = (ND + DPC - 1) / DPC;
  localparam int W    = 3 * XLEN;
  localparam int LAT  = NC + 2;

  logic            clk;
  logic            rst;
  logic            flush;
  logic            mul_i_valid;
  logic            mul_i_ready;
  logic [1:0]      mul_i_op;
  logic [XLEN-1:0] mul_i_multiplicand;
  logic [XLEN-1:0] mul_i_multiplier;
  logic            mul_o_valid;
  logic            mul_o_ready;
  logic [XLEN-1:0] mul_o_res;
  logic [XLEN-1:0] mul_o_resh;
  logic [XLEN-1:0] mul_o_resl;

  lieat_exu_mul_iter #(.XLEN(XLEN), .DPC(DPC)) dut (
    .clk                (clk),
    .rst                (rst),
    .flush              (flush),
    .mul_i_valid        (mul_i_valid),
    .mul_i_ready        (mul_i_ready),
    .mul_i_op           (mul_i_op),
    .mul_i_multiplicand (mul_i_multiplicand),
    .mul_i_multiplier   (mul_i_multiplier),
    .mul_o_valid        (mul_o_valid),
    .mul_o_ready        (mul_o_ready),
    .mul_o_res          (mul_o_res),
    .mul_o_resh         (mul_o_resh),
    .mul_o_resl         (mul_o_resl)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_tests;
  int n_fail;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [1:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] res;
    logic [XLEN-1:0] resh;
    logic [XLEN-1:0] resl;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: sign/zero-extend to 2*XLEN and take the modular product.
  function automatic logic [W-1:0] ref_model(input logic [1:0] op, input logic [XLEN-1:0] a,
                                             input logic [XLEN-1:0] b);
    logic [2*XLEN-1:0] ae, be, p;
    ae = (op == 2'b01 || op == 2'b10) ? {{XLEN{a[XLEN-1]}}, a} : {{XLEN{1'b0}}, a};
    be = (op == 2'b01) ? {{XLEN{b[XLEN-1]}}, b} : {{XLEN{1'b0}}, b};
    p  = ae * be;
    return {(op == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN], p[2*XLEN-1:XLEN], p[XLEN-1:0]};
  endfunction

  // ---------------- driver tasks ----------------
  // Drives one request and returns #1 after the accept edge.
  task automatic send(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    int guard;
    guard = 0;
    while (!mul_i_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!mul_i_ready) check("send_ready_timeout", 128'(mul_i_ready), 128'(1'b1));
    mul_i_valid        = 1'b1;
    mul_i_op           = op;
    mul_i_multiplicand = a;
    mul_i_multiplier   = b;
    @(posedge clk); #1;
    mul_i_valid        = 1'b0;
  endtask

  // Latency = number of edges from accept until mul_o_valid is seen high.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!mul_o_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic pop_compare(input string name);
    logic [W-1:0] exp;
    if (exp_q.size() == 0) begin
      check({name, "_queue_empty"}, 128'(1'b1), 128'(1'b0));
    end else begin
      exp = exp_q.pop_front();
      check(name, 128'({mul_o_res, mul_o_resh, mul_o_resl}), 128'(exp));
    end
  endtask

  // Full transaction with mul_o_ready held high by the caller.
  task automatic run_op(input string name, input logic [1:0] op, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic [W-1:0] exp, input int exp_lat);
    int lat;
    exp_q.push_back(exp);
    send(op, a, b);
    wait_valid(lat);
    check({name, "_latency"}, 128'(lat), 128'(exp_lat));
    check({name, "_valid"}, 128'(mul_o_valid), 128'(1'b1));
    pop_compare(name);
    @(posedge clk); #1;
  endtask

  task automatic watch_no_valid(input string name, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (mul_o_valid) seen = 1'b1;
    end
    check(name, 128'(seen), 128'(1'b0));
  endtask

  // ---------------- test ----------------
  initial begin
    logic [1:0]      r_op;
    logic [XLEN-1:0] r_a, r_b;
    logic [XLEN-1:0] hold_res, hold_resh, hold_resl;
    int              lat;

    n_tests = 0;
    n_fail  = 0;

    vecs[0]  = '{2'b00, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A, 32'h0000_0000, 32'h0000_002A};
    vecs[1]  = '{2'b01, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 32'h8000_0000};
    vecs[2]  = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[3]  = '{2'b10, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[4]  = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[5]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
    vecs[6]  = '{2'b01, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vecs[7]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[8]  = '{2'b11, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000};
    vecs[9]  = '{2'b00, 32'h0000_0003, 32'h0000_0005, 32'h0000_000F, 32'h0000_0000, 32'h0000_000F};
    vecs[10] = '{2'b00, 32'h0000_0000, 32'h0000_1234, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    vecs[11] = '{2'b01, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};

    rst                = 1'b1;
    flush              = 1'b0;
    mul_i_valid        = 1'b0;
    mul_i_op           = 2'b00;
    mul_i_multiplicand = '0;
    mul_i_multiplier   = '0;
    mul_o_ready        = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    check("reset_i_ready", 128'(mul_i_ready), 128'(1'b1));
    check("reset_o_valid", 128'(mul_o_valid), 128'(1'b0));
    check("reset_results", 128'({mul_o_res, mul_o_resh, mul_o_resl}), 128'(0));

    // Table vectors.
    for (int i = 0; i < 12; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             {vecs[i].res, vecs[i].resh, vecs[i].resl},
             (vecs[i].a == '0 || vecs[i].b == '0) ? 1 : LAT);
    end

    // Zero early-out followed by a 3-cycle consumer stall.
    mul_o_ready = 1'b0;
    exp_q.push_back({XLEN'(0), XLEN'(0), XLEN'(0)});
    send(2'b00, 32'h0000_0000, 32'h0000_1234);
    wait_valid(lat);
    check("stall_latency", 128'(lat), 128'(1));
    hold_res  = mul_o_res;
    hold_resh = mul_o_resh;
    hold_resl = mul_o_resl;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("stall_valid%0d", i), 128'(mul_o_valid), 128'(1'b1));
      check($sformatf("stall_i_ready%0d", i), 128'(mul_i_ready), 128'(1'b0));
      check($sformatf("stall_hold%0d", i), 128'({mul_o_res, mul_o_resh, mul_o_resl}),
            128'({hold_res, hold_resh, hold_resl}));
    end
    pop_compare("stall_result");
    mul_o_ready = 1'b1;
    @(posedge clk); #1;
    check("stall_release_i_ready", 128'(mul_i_ready), 128'(1'b1));

    // Flush in the third CALC cycle, then a normal op.
    send(2'b00, 32'h0000_0009, 32'h0000_000B);
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_i_ready", 128'(mul_i_ready), 128'(1'b1));
    check("flush_o_valid", 128'(mul_o_valid), 128'(1'b0));
    watch_no_valid("flush_no_result", NC + 4);
    run_op("post_flush", 2'b00, 32'h0000_0003, 32'h0000_0005, {32'hF, 32'h0, 32'hF}, LAT);

    // Flush beats a same-cycle accept.
    flush              = 1'b1;
    mul_i_valid        = 1'b1;
    mul_i_op           = 2'b00;
    mul_i_multiplicand = 32'h2;
    mul_i_multiplier   = 32'h2;
    @(posedge clk); #1;
    flush       = 1'b0;
    mul_i_valid = 1'b0;
    check("flush_accept_i_ready", 128'(mul_i_ready), 128'(1'b1));
    watch_no_valid("flush_accept_no_result", NC + 4);

    // Reset in the middle of an operation.
    send(2'b11, 32'h1234_5678, 32'h9ABC_DEF0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_i_ready", 128'(mul_i_ready), 128'(1'b1));
    check("midrst_o_valid", 128'(mul_o_valid), 128'(1'b0));
    check("midrst_results", 128'({mul_o_res, mul_o_resh, mul_o_resl}), 128'(0));

    // Random ops against the reference model.
    for (int i = 0; i < 300; i++) begin
      r_op = 2'($urandom_range(0, 3));
      r_a  = ($urandom_range(0, 15) == 0) ? '0 : XLEN'($urandom);
      r_b  = ($urandom_range(0, 15) == 0) ? '0 : XLEN'($urandom);
      if ($urandom_range(0, 7) == 0) r_a = {1'b1, {(XLEN-1){1'b0}}};
      if ($urandom_range(0, 7) == 0) r_b = '1;
      run_op($sformatf("rnd%0d", i), r_op, r_a, r_b, ref_model(r_op, r_a, r_b),
             (r_a == '0 || r_b == '0) ? 1 : LAT);
    end

    check("final_queue_empty", 128'(exp_q.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
